// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag field layout, command encodings, FSM states
// and the pending-read queue entry.
package sysbus_pkg;

    localparam int SYSBUS_DW      = 64;
    localparam int SYSBUS_TW      = 13;
    localparam int LINE_LSB       = 6;
    localparam int LINE_W         = SYSBUS_DW - LINE_LSB;

    localparam int TAG_RW_BIT     = 12;
    localparam int TAG_TYPE_LSB   = 8;
    localparam int TAG_TYPE_W     = 4;

    localparam logic                  SYSBUS_READ   = 1'b1;
    localparam logic                  SYSBUS_WRITE  = 1'b0;
    localparam logic [TAG_TYPE_W-1:0] SYSBUS_MEMORY = 4'b0001;

    localparam int BEATS_PER_LINE = 8;
    localparam int BEAT_W         = $clog2(BEATS_PER_LINE);

    typedef enum logic {REQ_IDLE, REQ_WDATA} req_state_t;
    typedef enum logic [1:0] {RSP_IDLE, RSP_WAIT, RSP_BURST} rsp_state_t;

    typedef struct packed {
        logic [LINE_W-1:0]    line;
        logic [SYSBUS_TW-1:0] tag;
    } req_entry_t;

    function automatic logic [TAG_TYPE_W-1:0] tag_type(input logic [SYSBUS_TW-1:0] t);
        return t[TAG_TYPE_LSB +: TAG_TYPE_W];
    endfunction

endpackage

// File: rtl/sysbus_req_fifo.sv
// Small synchronous FIFO holding pending read headers; push is ignored when
// full, pop is ignored when empty.
module sysbus_req_fifo #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_dout
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [PW:0]      r_count;
    logic             w_do_push, w_do_pop;

    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_mem[r_rp];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp] <= i_din;
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus endpoint: accepts read/write line requests and answers
// reads in order with eight-beat bursts after a fixed latency.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int READ_LATENCY   = 4,
    parameter int REQ_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      err_sticky
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    logic [BUS_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    req_state_t        r_req_st, w_req_nx;
    rsp_state_t        r_rsp_st, w_rsp_nx;
    logic [LINE_W-1:0] r_wline;
    logic [BEAT_W-1:0] r_wbeat, r_rbeat;
    logic [CW-1:0]     r_cnt;
    req_entry_t        r_cur, w_fifo_dout, w_fifo_din;
    logic              r_err;

    logic              w_is_mem, w_is_rd, w_push, w_pop, w_full, w_empty;
    logic              w_wr_en, w_whdr, w_err_set;
    logic [AW-1:0]     w_widx, w_ridx;

    assign w_is_mem   = (tag_type(bus_reqtag) == SYSBUS_MEMORY);
    assign w_is_rd    = (bus_reqtag[TAG_RW_BIT] == SYSBUS_READ);
    assign w_fifo_din = '{line: bus_req[BUS_DATA_WIDTH-1:LINE_LSB], tag: bus_reqtag};

    // Word index is {line, beat} truncated: wraps modulo MEM_WORDS.
    assign w_widx = AW'({r_wline, r_wbeat});
    assign w_ridx = AW'({r_cur.line, r_rbeat});

    sysbus_req_fifo #(
        .WIDTH ($bits(req_entry_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_dout  (w_fifo_dout)
    );

    always_comb begin
        w_req_nx   = r_req_st;
        bus_reqack = 1'b0;
        w_push     = 1'b0;
        w_wr_en    = 1'b0;
        w_whdr     = 1'b0;
        w_err_set  = 1'b0;
        case (r_req_st)
            REQ_IDLE: if (bus_reqcyc) begin
                if (!w_is_mem) begin
                    bus_reqack = 1'b1;
                    w_err_set  = 1'b1;
                end else if (w_is_rd) begin
                    // Full queue stalls the initiator; a same-cycle pop does not help.
                    bus_reqack = !w_full;
                    w_push     = !w_full;
                end else begin
                    bus_reqack = 1'b1;
                    w_whdr     = 1'b1;
                    w_req_nx   = REQ_WDATA;
                end
            end
            REQ_WDATA: if (bus_reqcyc) begin
                bus_reqack = 1'b1;
                w_wr_en    = 1'b1;
                if (r_wbeat == BEAT_W'(BEATS_PER_LINE - 1)) w_req_nx = REQ_IDLE;
            end
            default: w_req_nx = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_st <= REQ_IDLE;
            r_wline  <= '0;
            r_wbeat  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_req_st <= w_req_nx;
            if (w_whdr) begin
                r_wline <= bus_req[BUS_DATA_WIDTH-1:LINE_LSB];
                r_wbeat <= '0;
            end
            if (w_wr_en)   r_wbeat <= r_wbeat + 1'b1;
            if (w_err_set) r_err   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) r_mem[w_widx] <= bus_req;
    end

    always_comb begin
        w_rsp_nx = r_rsp_st;
        w_pop    = 1'b0;
        case (r_rsp_st)
            RSP_IDLE: if (!w_empty) begin
                w_pop    = 1'b1;
                w_rsp_nx = RSP_WAIT;
            end
            RSP_WAIT: if (r_cnt == '0) w_rsp_nx = RSP_BURST;
            RSP_BURST: if (bus_respack && r_rbeat == BEAT_W'(BEATS_PER_LINE - 1))
                w_rsp_nx = RSP_IDLE;
            default: w_rsp_nx = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_st <= RSP_IDLE;
            r_cur    <= '0;
            r_cnt    <= '0;
            r_rbeat  <= '0;
        end else begin
            r_rsp_st <= w_rsp_nx;
            case (r_rsp_st)
                RSP_IDLE: if (w_pop) begin
                    r_cur <= w_fifo_dout;
                    r_cnt <= CW'(READ_LATENCY);
                end
                RSP_WAIT: begin
                    if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
                    else             r_rbeat <= '0;
                end
                RSP_BURST: if (bus_respack) r_rbeat <= r_rbeat + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus_respcyc = (r_rsp_st == RSP_BURST);
    assign bus_resp    = bus_respcyc ? r_mem[w_ridx] : '0;
    assign bus_resptag = bus_respcyc ? r_cur.tag : '0;
    assign err_sticky  = r_err;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: expected beats are queued on
// read acceptance and checked as response beats transfer.
module tb_sysbus_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc, bus_reqack, bus_respcyc, bus_respack, err_sticky;
    logic [63:0] bus_req, bus_resp;
    logic [12:0] bus_reqtag, bus_resptag;

    typedef struct {
        logic [63:0] data;
        logic [12:0] tag;
        int          beat;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] model [4096];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, n_xfer = 0;
    int          rmode = 2, rdiv = 0;
    logic        hold, gap;
    logic [63:0] hold_data;
    logic [12:0] hold_tag;

    sysbus_mem_responder #(.READ_LATENCY(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, obs, exp, cyc);
        end
    endtask

    // respack pattern: 0 = always, 1 = every third cycle, 2 = never
    initial begin
        bus_respack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: bus_respack = 1'b1;
                1: begin bus_respack = (rdiv == 2); rdiv = (rdiv + 1) % 3; end
                default: bus_respack = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
            gap  = 1'b0;
        end else begin
            if (gap) begin
                chk("gap_after_burst", bus_respcyc, 0);
                gap = 1'b0;
            end
            if (hold)
                chk("beat_held", {bus_respcyc, bus_resptag, bus_resp}, {1'b1, hold_tag, hold_data});
            hold = 1'b0;
            if (bus_respcyc) begin
                if (sbq.size() == 0) chk("unexpected_resp", 1, 0);
                else if (bus_respack) begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_data", bus_resp, e.data);
                    chk("resp_tag", bus_resptag, e.tag);
                    n_xfer++;
                    if (e.beat == 7) gap = 1'b1;
                end else begin
                    hold      = 1'b1;
                    hold_data = bus_resp;
                    hold_tag  = bus_resptag;
                end
            end
        end
    end

    // Called just after a posedge; returns just after the transfer edge.
    task automatic req_beat(input logic [63:0] d, input logic [12:0] t, output int acc);
        int n = 0;
        bus_reqcyc = 1'b1; bus_req = d; bus_reqtag = t;
        forever begin
            @(negedge clk);
            if (bus_reqack) break;
            if (++n > 200) begin chk("reqack_timeout", 0, 1); break; end
        end
        acc = cyc;
        @(posedge clk); #1;
        bus_reqcyc = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [12:0] t, output int acc);
        int line = int'(addr[63:6]);
        req_beat(addr, t, acc);
        for (int i = 0; i < 8; i++)
            sbq.push_back('{data: model[(line*8 + i) % 4096], tag: t, beat: i});
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] base);
        int acc;
        int line = int'(addr[63:6]);
        req_beat(addr, 13'h0100, acc);
        for (int i = 0; i < 8; i++) begin
            req_beat(base + 64'(i), 13'h0, acc);
            model[(line*8 + i) % 4096] = base + 64'(i);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0) begin
            @(negedge clk);
            if (++n > 400) begin chk("drain_timeout", sbq.size(), 0); sbq.delete(); end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, n, n0, acks, rises;
        reset = 1'b1; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_reqack", bus_reqack, 0);
        chk("rst_respcyc", bus_respcyc, 0);
        chk("rst_resp", bus_resp, 0);
        chk("rst_resptag", bus_resptag, 0);
        chk("rst_err", err_sticky, 0);
        @(posedge clk); #1;

        // preload line 5 and read it back with full-rate acks
        rmode = 0;
        do_write(64'h140, 64'h1000);
        do_read(64'h140, 13'h1100, acc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_respcyc && n < 100);
        chk("first_beat_latency", cyc - acc, 3 + LAT);
        drain();

        // slow acks: beats held until taken, exactly eight transfers
        rmode = 1;
        n0 = n_xfer;
        do_read(64'h140, 13'h1100, acc);
        drain();
        chk("slow_xfer_count", n_xfer - n0, 8);

        // write line 8 then read it back; low address bits ignored
        rmode = 0;
        do_write(64'h200, 64'hA0);
        do_read(64'h23f, 13'h1101, acc);
        drain();

        // queue fill: five reads fit (one popped + four queued), the sixth stalls
        rmode = 2;
        for (int k = 0; k < 5; k++)
            do_read((k % 2) ? 64'h200 : 64'h140, 13'h1100 | 13'(k), acc);
        bus_reqcyc = 1'b1; bus_req = 64'h140; bus_reqtag = 13'h1105;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_reqack) acks++;
        end
        chk("full_queue_stall", acks, 0);
        @(posedge clk); #1;
        rmode = 0;
        do_read(64'h140, 13'h1105, acc);
        drain();

        // unsupported type: acked, no response, sticky error
        req_beat(64'h300, 13'h1200, acc);
        chk("err_set", err_sticky, 1);
        repeat (20) @(negedge clk);
        chk("err_sticky_hold", err_sticky, 1);
        chk("err_no_resp", sbq.size(), 0);
        @(posedge clk); #1;

        // reset in the middle of a burst
        n0 = n_xfer;
        do_read(64'h140, 13'h1106, acc);
        n = 0;
        forever begin
            @(posedge clk); #3;
            if (n_xfer - n0 == 3) break;
            if (++n > 100) begin chk("mid_burst_timeout", n_xfer - n0, 3); break; end
        end
        reset = 1'b1; rmode = 2; bus_respack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_burst_respcyc", bus_respcyc, 0);
        chk("rst_clears_err", err_sticky, 0);
        sbq.delete();
        @(posedge clk); #1 reset = 1'b0;
        rises = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus_respcyc) rises++;
        end
        chk("queue_flushed", rises, 0);
        @(posedge clk); #1;
        rmode = 0;
        do_read(64'h200, 13'h1107, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
